// File: rtl/cpu_fetch_seq.sv
// -----------------------------------------------------------------------------
// cpu_fetch_seq
//
// Purpose:
//    Instruction-fetch sequencer for a small CPU core. It divides the clock into
//    M-cycles of T_PER_M T-cycles and owns the program counter and the
//    instruction register. It also owns the RUN/HALT state. PC and instruction
//    register updates happen only on an M-cycle boundary. A stall freezes the
//    T-cycle counter, and with it any pending boundary.
//
// Parameters:
//    ADDR_WIDTH  width of the program counter and the absolute load value
//    DATA_WIDTH  width of the opcode bus, instruction register and rel offset
//    T_PER_M     T-cycles per M-cycle (2..16)
//    RESET_PC    program counter value after reset
//
// Ports:
//    i_clk                   single clock, all state changes on rising edge
//    i_reset                 synchronous active-high reset, overrides all
//    i_stall                 freezes the T-cycle counter (bus wait / DMA hold)
//    i_pc_op                 PC update select: 0 Same, 1 Inc, 2 Load, 3 Rel
//    i_pc_load_value         absolute target for Load
//    i_pc_rel                two's-complement offset for Rel (no implicit +1)
//    i_inst_load             capture i_mem_data_in at the M-cycle end
//    i_mem_data_in           system bus read data
//    i_halt_req              request entry to the halted state
//    i_wake                  pending-interrupt wake request
//    o_t_phase               current T-cycle index within the M-cycle
//    o_m_cycle               M-cycle boundary strobe (combinational)
//    o_pc                    current program counter / fetch address
//    o_instruction_register  current opcode
//    o_halted                core is halted
//
// Registers have no declaration initialisers. The power-up state is produced
// by the synchronous reset, so reset must be asserted for at least one edge
// after power-up.
// -----------------------------------------------------------------------------
module cpu_fetch_seq #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int T_PER_M    = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_stall,
   input  logic [1:0]                   i_pc_op,
   input  logic [ADDR_WIDTH-1:0]        i_pc_load_value,
   input  logic [DATA_WIDTH-1:0]        i_pc_rel,
   input  logic                         i_inst_load,
   input  logic [DATA_WIDTH-1:0]        i_mem_data_in,
   input  logic                         i_halt_req,
   input  logic                         i_wake,
   output logic [$clog2(T_PER_M)-1:0]   o_t_phase,
   output logic                         o_m_cycle,
   output logic [ADDR_WIDTH-1:0]        o_pc,
   output logic [DATA_WIDTH-1:0]        o_instruction_register,
   output logic                         o_halted
);

   localparam int TW = $clog2(T_PER_M);

   // Last T-cycle of an M-cycle. The boundary strobe fires here when not stalled.
   localparam logic [TW-1:0]         LAST_PHASE = TW'(T_PER_M - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_RST     = ADDR_WIDTH'(RESET_PC);

   localparam logic [1:0] PC_SAME = 2'd0;
   localparam logic [1:0] PC_INC  = 2'd1;
   localparam logic [1:0] PC_LOAD = 2'd2;
   localparam logic [1:0] PC_REL  = 2'd3;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Next program counter for a given update select. Rel sign-extends the
   // offset to address width and adds it to the current PC; the sum wraps
   // modulo 2^ADDR_WIDTH, as does Inc.
   function automatic logic [ADDR_WIDTH-1:0] pc_next_f(
      input logic [1:0]            op,
      input logic [ADDR_WIDTH-1:0] pc,
      input logic [ADDR_WIDTH-1:0] load_value,
      input logic [DATA_WIDTH-1:0] rel
   );
      logic signed [DATA_WIDTH-1:0] rel_s;
      logic [ADDR_WIDTH-1:0]        result;
      rel_s = rel;
      case (op)
         PC_SAME: result = pc;
         PC_INC:  result = pc + ADDR_WIDTH'(1'b1);
         PC_LOAD: result = load_value;
         PC_REL:  result = pc + ADDR_WIDTH'(rel_s);
         default: result = pc;
      endcase
      return result;
   endfunction

   logic [TW-1:0]          r_t_phase;
   logic [ADDR_WIDTH-1:0]  r_pc;
   logic [DATA_WIDTH-1:0]  r_ir;
   logic                   r_halted;
   state_t                 r_state;

   logic                   w_m_cycle;
   logic                   w_phase_last;
   logic [TW-1:0]          w_t_phase_next;
   logic [ADDR_WIDTH-1:0]  w_pc_next;

   // The boundary is the last T-cycle, and only when it actually completes.
   // A stall at that point holds the boundary until the first unstalled edge.
   assign w_phase_last = (r_t_phase == LAST_PHASE);
   assign w_m_cycle    = w_phase_last & ~i_stall;

   // Explicit wrap so that T_PER_M values that are not powers of two count correctly.
   assign w_t_phase_next = w_phase_last ? {TW{1'b0}} : (r_t_phase + TW'(1'b1));

   assign w_pc_next = pc_next_f(i_pc_op, r_pc, i_pc_load_value, i_pc_rel);

   // T-cycle counter: advances when not stalled; reset discards a partial M-cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_t_phase <= {TW{1'b0}};
      end else if (!i_stall) begin
         r_t_phase <= w_t_phase_next;
      end else begin
         r_t_phase <= r_t_phase;
      end
   end

   // RUN/HALT sequencer together with the PC, instruction register and halted flag.
   // Nothing here changes except on an M-cycle boundary or on reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
         r_pc     <= PC_RST;
         r_ir     <= {DATA_WIDTH{1'b0}};
      end else if (w_m_cycle) begin
         case (r_state)
            ST_RUN: begin
               // The M-cycle that requests the halt still completes its own
               // PC/IR work. A simultaneous wake cancels the halt request.
               r_pc <= w_pc_next;
               if (i_inst_load) begin
                  r_ir <= i_mem_data_in;
               end else begin
                  r_ir <= r_ir;
               end
               if (i_halt_req && !i_wake) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            ST_HALT: begin
               // PC and IR hold, including on the waking edge. Fetch resumes
               // on the following M-cycle. halt_req has no effect here.
               r_pc <= r_pc;
               r_ir <= r_ir;
               if (i_wake) begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end else begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_RUN;
               r_halted <= 1'b0;
               r_pc     <= r_pc;
               r_ir     <= r_ir;
            end
         endcase
      end else begin
         r_state  <= r_state;
         r_halted <= r_halted;
         r_pc     <= r_pc;
         r_ir     <= r_ir;
      end
   end

   assign o_t_phase              = r_t_phase;
   assign o_m_cycle              = w_m_cycle;
   assign o_pc                   = r_pc;
   assign o_instruction_register = r_ir;
   assign o_halted               = r_halted;

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_fetch_seq
//
// Drives two instances of cpu_fetch_seq from the same stimulus:
//    A: defaults (ADDR_WIDTH 16, T_PER_M 4)
//    B: ADDR_WIDTH 12, T_PER_M 2
// Both are compared each clock against a behavioural model that works on
// integers (modular arithmetic, a phase count and a halted flag).
// -----------------------------------------------------------------------------
module tb_cpu_fetch_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pc_op = 2'd0;
   logic [15:0] load_val = 16'h0000;
   logic [7:0]  rel = 8'h00;
   logic        inst_load = 1'b0;
   logic [7:0]  mem_data = 8'h00;
   logic        halt_req = 1'b0;
   logic        wake = 1'b0;

   logic [1:0]  a_tph;
   logic        a_mc;
   logic [15:0] a_pc;
   logic [7:0]  a_ir;
   logic        a_hlt;

   logic [0:0]  b_tph;
   logic        b_mc;
   logic [11:0] b_pc;
   logic [7:0]  b_ir;
   logic        b_hlt;

   int n_vec = 0;
   int n_err = 0;

   // Model state, index 0 = instance A, 1 = instance B
   int m_ph  [2] = '{0, 0};
   int m_pc  [2] = '{0, 0};
   int m_ir  [2] = '{0, 0};
   bit m_hlt [2] = '{1'b0, 1'b0};
   int m_t   [2] = '{4, 2};
   int m_mod [2] = '{65536, 4096};

   always #5 clk = ~clk;

   cpu_fetch_seq dut_a (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_stall                (stall),
      .i_pc_op                (pc_op),
      .i_pc_load_value        (load_val),
      .i_pc_rel               (rel),
      .i_inst_load            (inst_load),
      .i_mem_data_in          (mem_data),
      .i_halt_req             (halt_req),
      .i_wake                 (wake),
      .o_t_phase              (a_tph),
      .o_m_cycle              (a_mc),
      .o_pc                   (a_pc),
      .o_instruction_register (a_ir),
      .o_halted               (a_hlt)
   );

   cpu_fetch_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .T_PER_M(2), .RESET_PC(0)) dut_b (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_stall                (stall),
      .i_pc_op                (pc_op),
      .i_pc_load_value        (load_val[11:0]),
      .i_pc_rel               (rel),
      .i_inst_load            (inst_load),
      .i_mem_data_in          (mem_data),
      .i_halt_req             (halt_req),
      .i_wake                 (wake),
      .o_t_phase              (b_tph),
      .o_m_cycle              (b_mc),
      .o_pc                   (b_pc),
      .o_instruction_register (b_ir),
      .o_halted               (b_hlt)
   );

   // Single comparison point: counts every vector and reports miscompares
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one rising edge with the current inputs
   task automatic model_step();
      int srel;
      bit bnd;
      srel = (rel >= 8'd128) ? (int'(rel) - 256) : int'(rel);
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_ph[k] = 0; m_pc[k] = 0; m_ir[k] = 0; m_hlt[k] = 1'b0;
         end else if (!stall) begin
            bnd = (m_ph[k] == m_t[k] - 1);
            m_ph[k] = (m_ph[k] + 1) % m_t[k];
            if (bnd) begin
               if (!m_hlt[k]) begin
                  case (pc_op)
                     2'd1: m_pc[k] = (m_pc[k] + 1) % m_mod[k];
                     2'd2: m_pc[k] = int'(load_val) % m_mod[k];
                     2'd3: m_pc[k] = (m_pc[k] + srel + m_mod[k]) % m_mod[k];
                     default: m_pc[k] = m_pc[k];
                  endcase
                  if (inst_load) m_ir[k] = int'(mem_data);
                  if (halt_req && !wake) m_hlt[k] = 1'b1;
               end else if (wake) begin
                  m_hlt[k] = 1'b0;
               end
            end
         end
      end
   endtask

   // One clock: drive at negedge, check the strobe, cross the edge, check state
   task automatic drive_cycle(input logic r, input logic s, input logic [1:0] op,
                              input logic [15:0] lv, input logic [7:0] rl, input logic il,
                              input logic [7:0] md, input logic hr, input logic wk);
      @(negedge clk);
      reset = r; stall = s; pc_op = op; load_val = lv; rel = rl;
      inst_load = il; mem_data = md; halt_req = hr; wake = wk;
      #1;
      check_val("a_mcycle", a_mc, (m_ph[0] == m_t[0] - 1) && !s);
      check_val("b_mcycle", b_mc, (m_ph[1] == m_t[1] - 1) && !s);
      model_step();
      @(posedge clk);
      #1;
      check_val("a_tphase", a_tph, m_ph[0]);
      check_val("a_pc",     a_pc,  m_pc[0]);
      check_val("a_ir",     a_ir,  m_ir[0]);
      check_val("a_halted", a_hlt, m_hlt[0]);
      check_val("b_tphase", b_tph, m_ph[1]);
      check_val("b_pc",     b_pc,  m_pc[1]);
      check_val("b_ir",     b_ir,  m_ir[1]);
      check_val("b_halted", b_hlt, m_hlt[1]);
   endtask

   // One full unstalled M-cycle of instance A (four clocks)
   task automatic run_mcycle(input logic [1:0] op, input logic [15:0] lv, input logic [7:0] rl,
                             input logic hr, input logic wk);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, op, lv, rl, 1'b0, 8'h00, hr, wk);
   endtask

   initial begin
      // Reset state
      drive_cycle(1'b1, 1'b0, 2'd0, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("rst_pc", a_pc, 32'h0);
      check_val("rst_halted", a_hlt, 32'h0);

      // Twelve clocks of Inc with opcode capture
      for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b1, 8'h3E, 1'b0, 1'b0);
      check_val("inc12_pc", a_pc, 32'h0003);
      check_val("inc12_ir", a_ir, 32'h003E);
      check_val("inc12_b_pc", b_pc, 32'h006);

      // Wrap at the top of the address space for both widths
      run_mcycle(2'd2, 16'hFFFF, 8'h00, 1'b0, 1'b0);
      check_val("load_ffff", a_pc, 32'hFFFF);
      for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("b_wrap", b_pc, 32'h000);
      for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("a_wrap", a_pc, 32'h0000);

      // Relative and absolute jumps
      run_mcycle(2'd2, 16'h0150, 8'h00, 1'b0, 1'b0);
      run_mcycle(2'd3, 16'h0000, 8'hFE, 1'b0, 1'b0);
      check_val("rel_neg", a_pc, 32'h014E);
      run_mcycle(2'd2, 16'h0150, 8'h00, 1'b0, 1'b0);
      run_mcycle(2'd3, 16'h0000, 8'h05, 1'b0, 1'b0);
      check_val("rel_pos", a_pc, 32'h0155);
      run_mcycle(2'd2, 16'hC000, 8'h00, 1'b0, 1'b0);
      check_val("load_c000", a_pc, 32'hC000);

      // Stall held three clocks at the last T-cycle
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("stall_pc", a_pc, 32'hC000);
      check_val("stall_tph", a_tph, 32'h3);
      drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("stall_rel_pc", a_pc, 32'hC001);
      check_val("stall_rel_tph", a_tph, 32'h0);

      // Halt, ignore three M-cycles, wake, resume
      run_mcycle(2'd2, 16'h0100, 8'h00, 1'b0, 1'b0);
      run_mcycle(2'd1, 16'h0000, 8'h00, 1'b1, 1'b0);
      check_val("halt_pc", a_pc, 32'h0101);
      check_val("halt_flag", a_hlt, 32'h1);
      for (int i = 0; i < 3; i++) run_mcycle(2'd1, 16'h0000, 8'h00, 1'b0, 1'b0);
      check_val("halted_hold", a_pc, 32'h0101);
      run_mcycle(2'd1, 16'h0000, 8'h00, 1'b0, 1'b1);
      check_val("wake_flag", a_hlt, 32'h0);
      check_val("wake_pc", a_pc, 32'h0101);
      run_mcycle(2'd1, 16'h0000, 8'h00, 1'b0, 1'b0);
      check_val("resume_pc", a_pc, 32'h0102);

      // halt_req with wake stays in RUN; reset while halted mid-M-cycle
      run_mcycle(2'd1, 16'h0000, 8'h00, 1'b1, 1'b1);
      check_val("hw_flag", a_hlt, 32'h0);
      check_val("hw_pc", a_pc, 32'h0103);
      run_mcycle(2'd0, 16'h0000, 8'h00, 1'b1, 1'b0);
      check_val("halt2_flag", a_hlt, 32'h1);
      for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 2'd1, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
      check_val("pre_rst_tph", a_tph, 32'h2);
      drive_cycle(1'b1, 1'b1, 2'd1, 16'hFFFF, 8'h0, 1'b1, 8'hAA, 1'b1, 1'b0);
      check_val("rst_mid_pc", a_pc, 32'h0);
      check_val("rst_mid_halted", a_hlt, 32'h0);
      check_val("rst_mid_tph", a_tph, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                     2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_seq.md
CPU_FETCH_SEQ -- requirements
Module: cpu_fetch_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of program counter and load value.
REQ-002 Parameter DATA_WIDTH, default 8, width of opcode bus, instruction register and relative offset.
REQ-003 Parameter T_PER_M, default 4, T-cycles per M-cycle; legal range 2..16.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 clk  input  1  single clock (normally 4 MHz); all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  freezes the T-cycle counter (bus wait or DMA hold).
REQ-008 pc_op  input  2  PC update select: 0 Same, 1 Inc, 2 Load, 3 Rel.
REQ-009 pc_load_value  input  ADDR_WIDTH  absolute target for Load.
REQ-010 pc_rel  input  DATA_WIDTH  two's-complement offset for Rel.
REQ-011 inst_load  input  1  capture mem_data_in into the instruction register at M-cycle end.
REQ-012 mem_data_in  input  DATA_WIDTH  system bus read data.
REQ-013 halt_req  input  1  request entry to halted state.
REQ-014 wake  input  1  pending-interrupt wake request.
REQ-015 t_phase  output  clog2(T_PER_M)  current T-cycle index within the M-cycle.
REQ-016 m_cycle  output  1  M-cycle boundary strobe.
REQ-017 pc  output  ADDR_WIDTH  current program counter, also the fetch address.
REQ-018 instruction_register  output  DATA_WIDTH  current opcode.
REQ-019 halted  output  1  core is halted.

Function
REQ-020 t_phase SHALL increment by 1 each clk when stall=0, wrap from T_PER_M-1 to 0, and hold when stall=1.
REQ-021 m_cycle SHALL be combinationally high iff t_phase==T_PER_M-1 and stall=0.
REQ-022 pc, instruction_register and halted SHALL change only on an edge where m_cycle=1 (reset excepted).
REQ-023 With halted=0 at m_cycle, pc_op Same SHALL hold pc.
REQ-024 With halted=0 at m_cycle, pc_op Inc SHALL set pc to pc+1 modulo 2^ADDR_WIDTH; 0xFFFF wraps to 0x0000 at default width.
REQ-025 With halted=0 at m_cycle, pc_op Load SHALL set pc to pc_load_value.
REQ-026 With halted=0 at m_cycle, pc_op Rel SHALL set pc to pc + sign-extended pc_rel modulo 2^ADDR_WIDTH, with no implicit +1.
REQ-027 With halted=0 at m_cycle and inst_load=1, instruction_register SHALL take mem_data_in; otherwise it holds.
REQ-028 States: RUN (halted=0) and HALT (halted=1).
REQ-029 RUN->HALT SHALL occur at m_cycle when halt_req=1 and wake=0; the pc_op and inst_load of that M-cycle SHALL still take effect.
REQ-030 halt_req=1 and wake=1 together in RUN SHALL leave the block in RUN, with normal pc_op and inst_load.
REQ-031 In HALT, pc_op and inst_load SHALL be ignored; pc and instruction_register hold; t_phase keeps counting.
REQ-032 HALT->RUN SHALL occur at m_cycle when wake=1; pc and instruction_register SHALL hold on that edge, and updates resume from the next M-cycle.
REQ-033 halt_req in HALT SHALL have no effect.
REQ-034 stall asserted at t_phase==T_PER_M-1 SHALL suppress m_cycle and all updates until it deasserts; the boundary then completes on the first unstalled edge.

Reset
REQ-035 reset=1 on an edge SHALL set t_phase=0, pc=RESET_PC, instruction_register=0 and halted=0, overriding stall and all other inputs.
REQ-036 Reset mid-M-cycle SHALL discard the partial M-cycle; the first m_cycle after release SHALL be T_PER_M edges later.
REQ-037 Power-up register values SHALL equal the reset values.

Verification
REQ-038 Defaults, pc_op=Inc, inst_load=1, mem_data_in=0x3E, 12 clocks after reset -> m_cycle on clocks 4, 8 and 12; pc=0x0003; instruction_register=0x3E.
REQ-039 pc=0xFFFF, Inc -> 0x0000; pc=0x0150, Rel with pc_rel=0xFE -> 0x014E; Rel with pc_rel=0x05 -> 0x0155; Load with 0xC000 -> 0xC000.
REQ-040 stall held 3 clocks at t_phase=3 -> m_cycle low and pc frozen for those 3 clocks, then one update on release; total span 7 clocks.
REQ-041 halt_req at m_cycle with pc=0x0100 and Inc -> pc=0x0101 and halted=1; 3 further M-cycles with Inc -> pc stays 0x0101; wake -> halted=0 with pc=0x0101; next Inc -> 0x0102.
REQ-042 halt_req and wake together in RUN -> halted stays 0; reset asserted at t_phase=2 while halted -> pc=0, halted=0, t_phase=0.
REQ-043 T_PER_M=2, ADDR_WIDTH=12 -> m_cycle every 2 clocks; Inc from 0xFFF wraps to 0x000.
